ps2_char_writer: RTL and testbench
==================================

PS2_CHAR_WRITER -- requirements
Module: ps2_char_writer

Interface
REQ-001 Parameter BUFFER_WIDTH, default 12, characters per row.
REQ-002 Parameter BUFFER_HEIGHT, default 9, rows; CELLS = BUFFER_WIDTH*BUFFER_HEIGHT (108).
REQ-003 clk  input  1  100 MHz system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  PS/2 byte from the PS/2 receiver.
REQ-006 read_data  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 err  input  1  receiver error, qualifies read_data.
REQ-008 clear  input  1  synchronous request to blank the buffer.
REQ-009 lookup_addr  output  8  scancode-to-ASCII RAM address, {shift_held, scancode[6:0]}, registered.
REQ-010 ascii_in  input  8  ASCII RAM data, valid 1 cycle after lookup_addr changes; 0x00 means no character.
REQ-011 buf_we  output  1  one-cycle write strobe to the character buffer.
REQ-012 buf_addr  output  7  buffer cell index, 0..CELLS-1.
REQ-013 buf_data  output  8  ASCII byte to write.
REQ-014 cursor  output  7  next write cell.
REQ-015 shift_held  output  1  a shift key is down.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 overrun  output  1  sticky flag, cleared only by reset.

Function
REQ-018 The FSM SHALL have states IDLE, LOOKUP, WRITE and CLEAR.
REQ-019 In IDLE, a byte is accepted when read_data=1 and err=0.
- read_data=1 with err=1: byte discarded; break_flag and ext_flag cleared.
REQ-020 Byte 0xF0 SHALL set break_flag; 0xE0 SHALL set ext_flag; no state change.
REQ-021 Any other byte with ext_flag=1 SHALL be ignored; both flags cleared.
REQ-022 Any other byte with break_flag=1:
- 0x12 or 0x59 clears that shift bit (left/right tracked separately); else ignored.
- Flags cleared either way.
REQ-023 Make code 0x12/0x59 SHALL set the corresponding shift bit; shift_held = OR of both bits.
REQ-024 Make codes with bit7=1 SHALL be ignored.
REQ-025 Any other make code SHALL register lookup_addr and the key class (BKSP=0x66, ENTER=0x5A, else CHAR), then move to LOOKUP.
REQ-026 LOOKUP SHALL last one cycle, then go to WRITE.
REQ-027 WRITE (one cycle) SHALL act on the key class, then return to IDLE:
- CHAR, ascii_in≠0x00: buf_we=1, buf_addr=cursor, buf_data=ascii_in; cursor+1, wrapping CELLS-1 -> 0.
- CHAR, ascii_in=0x00: no write, cursor unchanged.
- BKSP, cursor>0: buf_addr=cursor-1, buf_data=0x20, buf_we=1; cursor-1.
- BKSP, cursor=0: no write, cursor unchanged.
- ENTER: no write; cursor = first cell of the next row; from the last row it wraps to 0.
REQ-028 buf_we, buf_addr and buf_data SHALL be registered:
- For a byte accepted in cycle N, buf_we is high in cycle N+3 only.
- cursor takes its new value in the same cycle.
REQ-029 buf_we SHALL never be high for more than one consecutive cycle, except in CLEAR.
REQ-030 read_data=1 while busy=1 SHALL drop the byte and set overrun; flags unchanged.
REQ-031 clear=1 in IDLE SHALL enter CLEAR:
- Writes 0x20 to cells 0..CELLS-1, one per cycle, ascending; buf_we high for exactly CELLS cycles.
- Then cursor=0, return to IDLE.
REQ-032 clear=1 in LOOKUP/WRITE SHALL be held pending and serviced on return to IDLE.
REQ-033 If clear=1 and an accepted byte arrive in the same IDLE cycle, clear SHALL win and the byte is dropped with overrun set.
REQ-034 All arithmetic on cursor SHALL be modulo CELLS; buf_addr SHALL never reach CELLS or above.

Reset
REQ-035 While reset=0, all outputs and state SHALL be reset, immediately and independent of clk:
- State IDLE.
- cursor=0, lookup_addr=0, buf_addr=0, buf_data=0x00.
- buf_we=0, shift_held=0, busy=0, overrun=0.
- break_flag=0, ext_flag=0, pending clear=0.
REQ-036 Reset asserted mid-LOOKUP, WRITE or CLEAR SHALL abort with no further buf_we.
REQ-037 The first byte SHALL be accepted on the first clk edge after reset deasserts.

Verification
REQ-038 Byte 0x1C at cycle N, ASCII RAM model returns 0x61 -> lookup_addr=0x1C in N+1; buf_we=1, addr 0, data 0x61 in N+3; cursor=1.
REQ-039 Byte sequence 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12 -> a single write at addr {1,0x1C}=0x9C lookup; shift_held falls after the final 0x12.
REQ-040 cursor=107 plus a printable key -> write at 107, cursor=0; ENTER at cursor=100 -> cursor=0; ENTER at cursor=13 -> 24.
REQ-041 Backspace at cursor=5 -> write 0x20 at 4, cursor=4; backspace at cursor=0 -> no buf_we.
REQ-042 clear pulse with cursor=40 -> 108 consecutive writes of 0x20 at 0..107, busy high throughout, then cursor=0.
REQ-043 read_data during WRITE -> byte dropped, overrun=1; reset=0 during CLEAR -> buf_we low at once, overrun=0.

Source files
------------

// File: rtl/ps2_char_writer.sv
// PS/2 scancode-to-character writer: decodes make/break codes, looks up ASCII through an
// external RAM and writes characters, backspaces, newlines and a full blank into a text buffer.
module ps2_char_writer #(
  parameter int unsigned BUFFER_WIDTH  = 12,
  parameter int unsigned BUFFER_HEIGHT = 9,
  localparam int unsigned Cells        = BUFFER_WIDTH * BUFFER_HEIGHT,
  localparam int unsigned Aw           = $clog2(Cells)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    rx_data_i,
  input  logic          read_data_i,
  input  logic          err_i,
  input  logic          clear_i,
  output logic [7:0]    lookup_addr_o,
  input  logic [7:0]    ascii_in_i,
  output logic          buf_we_o,
  output logic [Aw-1:0] buf_addr_o,
  output logic [7:0]    buf_data_o,
  output logic [Aw-1:0] cursor_o,
  output logic          shift_held_o,
  output logic          busy_o,
  output logic          overrun_o
);

  localparam logic [7:0] CodeBreak = 8'hF0;
  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeLShft = 8'h12;
  localparam logic [7:0] CodeRShft = 8'h59;
  localparam logic [7:0] CodeBksp  = 8'h66;
  localparam logic [7:0] CodeEnter = 8'h5A;
  localparam logic [7:0] Space     = 8'h20;

  typedef enum logic [1:0] {StIdle, StLookup, StWrite, StClear} state_e;
  typedef enum logic [1:0] {KeyChar, KeyBksp, KeyEnter} key_e;

  state_e        state_q;
  key_e          key_q;
  logic [Aw-1:0] cursor_q, buf_addr_q;
  logic [7:0]    lookup_addr_q, buf_data_q;
  logic          buf_we_q, overrun_q, shl_q, shr_q, brk_q, ext_q, clr_pend_q;

  logic [Aw-1:0] cur_inc, cur_dec, cur_nl;
  logic          accept;
  int unsigned   nl;

  always_comb begin
    cur_inc = (cursor_q == Aw'(Cells - 1)) ? '0 : cursor_q + Aw'(1);
    cur_dec = cursor_q - Aw'(1);
    nl      = (32'(cursor_q) / BUFFER_WIDTH + 32'd1) * BUFFER_WIDTH;
    cur_nl  = (nl >= Cells) ? '0 : Aw'(nl);
    accept  = read_data_i && !err_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      key_q         <= KeyChar;
      cursor_q      <= '0;
      buf_addr_q    <= '0;
      lookup_addr_q <= '0;
      buf_data_q    <= '0;
      buf_we_q      <= 1'b0;
      overrun_q     <= 1'b0;
      shl_q         <= 1'b0;
      shr_q         <= 1'b0;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      clr_pend_q    <= 1'b0;
    end else begin
      buf_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear_i || clr_pend_q) begin
            // First blank cell is issued on entry so buf_we tracks CLEAR exactly.
            state_q    <= StClear;
            clr_pend_q <= 1'b0;
            buf_we_q   <= 1'b1;
            buf_addr_q <= '0;
            buf_data_q <= Space;
            if (accept) overrun_q <= 1'b1;
          end else if (read_data_i) begin
            if (err_i) begin
              brk_q <= 1'b0;
              ext_q <= 1'b0;
            end else if (rx_data_i == CodeBreak) begin
              brk_q <= 1'b1;
            end else if (rx_data_i == CodeExt) begin
              ext_q <= 1'b1;
            end else if (ext_q) begin
              brk_q <= 1'b0;
              ext_q <= 1'b0;
            end else if (brk_q) begin
              brk_q <= 1'b0;
              if (rx_data_i == CodeLShft) shl_q <= 1'b0;
              if (rx_data_i == CodeRShft) shr_q <= 1'b0;
            end else if (rx_data_i == CodeLShft) begin
              shl_q <= 1'b1;
            end else if (rx_data_i == CodeRShft) begin
              shr_q <= 1'b1;
            end else if (!rx_data_i[7]) begin
              lookup_addr_q <= {shl_q | shr_q, rx_data_i[6:0]};
              key_q   <= (rx_data_i == CodeBksp)  ? KeyBksp :
                         (rx_data_i == CodeEnter) ? KeyEnter : KeyChar;
              state_q <= StLookup;
            end
          end
        end
        StLookup: begin
          if (clear_i)     clr_pend_q <= 1'b1;
          if (read_data_i) overrun_q  <= 1'b1;
          state_q <= StWrite;
        end
        StWrite: begin
          if (clear_i)     clr_pend_q <= 1'b1;
          if (read_data_i) overrun_q  <= 1'b1;
          state_q <= StIdle;
          unique case (key_q)
            KeyChar: begin
              if (ascii_in_i != 8'h00) begin
                buf_we_q   <= 1'b1;
                buf_addr_q <= cursor_q;
                buf_data_q <= ascii_in_i;
                cursor_q   <= cur_inc;
              end
            end
            KeyBksp: begin
              if (cursor_q != '0) begin
                buf_we_q   <= 1'b1;
                buf_addr_q <= cur_dec;
                buf_data_q <= Space;
                cursor_q   <= cur_dec;
              end
            end
            default: cursor_q <= cur_nl;
          endcase
        end
        StClear: begin
          if (read_data_i) overrun_q <= 1'b1;
          if (buf_addr_q == Aw'(Cells - 1)) begin
            state_q  <= StIdle;
            cursor_q <= '0;
          end else begin
            buf_we_q   <= 1'b1;
            buf_addr_q <= buf_addr_q + Aw'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lookup_addr_o = lookup_addr_q;
  assign buf_we_o      = buf_we_q;
  assign buf_addr_o    = buf_addr_q;
  assign buf_data_o    = buf_data_q;
  assign cursor_o      = cursor_q;
  assign shift_held_o  = shl_q | shr_q;
  assign busy_o        = (state_q != StIdle);
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_ps2_char_writer.sv
// Directed bench for ps2_char_writer with a registered scancode-to-ASCII RAM model.
module tb_ps2_char_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       read_data = 1'b0;
  logic       err = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] lookup_addr;
  logic [7:0] ascii_in = 8'h00;
  logic       buf_we;
  logic [6:0] buf_addr;
  logic [7:0] buf_data;
  logic [6:0] cursor;
  logic       shift_held;
  logic       busy;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int burst_err = 0;
  int snap;
  logic prev_we = 1'b0;

  always #5 clk = ~clk;

  ps2_char_writer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_data_i    (rx_data),
    .read_data_i  (read_data),
    .err_i        (err),
    .clear_i      (clear),
    .lookup_addr_o(lookup_addr),
    .ascii_in_i   (ascii_in),
    .buf_we_o     (buf_we),
    .buf_addr_o   (buf_addr),
    .buf_data_o   (buf_data),
    .cursor_o     (cursor),
    .shift_held_o (shift_held),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  function automatic logic [7:0] ascii_of(input logic [7:0] a);
    case (a)
      8'h1C:   return 8'h61;
      8'h9C:   return 8'h41;
      8'h15:   return 8'h71;
      8'h95:   return 8'h51;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) ascii_in <= ascii_of(lookup_addr);

  // Counts the cycle that just ended; flags two-cycle write bursts outside CLEAR.
  always @(posedge clk) begin
    if (buf_we === 1'b1) we_cnt <= we_cnt + 1;
    if (buf_we === 1'b1 && prev_we && busy !== 1'b1) burst_err <= burst_err + 1;
    prev_we <= (buf_we === 1'b1);
  end

  // Presents a byte for one cycle; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [7:0] b, input logic e);
    @(negedge clk);
    rx_data = b; err = e; read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0; err = 1'b0;
  endtask

  task automatic press(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      send(b, 1'b0);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({buf_we, busy, overrun, shift_held} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {buf_we, busy, overrun, shift_held});
    end
    tests++;
    if ({cursor, buf_addr, buf_data, lookup_addr} !== 30'h0) begin
      fails++; $display("FAIL reset_regs: cursor=%0d addr=%0d data=%h la=%h want all 0",
                        cursor, buf_addr, buf_data, lookup_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_char;
    send(8'h1C, 1'b0);
    tests++;
    if (lookup_addr !== 8'h1C) begin
      fails++; $display("FAIL char_lookup: got %h want 1c", lookup_addr);
    end
    @(negedge clk);
    tests++;
    if (buf_we !== 1'b0) begin fails++; $display("FAIL char_early_we: got %b want 0", buf_we); end
    @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data, cursor} !== {1'b1, 7'd0, 8'h61, 7'd1}) begin
      fails++; $display("FAIL char_write: we=%b addr=%0d data=%h cur=%0d want 1 0 61 1",
                        buf_we, buf_addr, buf_data, cursor);
    end
    @(negedge clk);
    tests++;
    if (buf_we !== 1'b0) begin fails++; $display("FAIL char_we_len: got %b want 0", buf_we); end
  endtask

  task automatic test_shift;
    snap = we_cnt;
    press(8'h12, 1);
    tests++;
    if (shift_held !== 1'b1) begin fails++; $display("FAIL shift_set: got %b want 1", shift_held); end
    send(8'h1C, 1'b0);
    tests++;
    if (lookup_addr !== 8'h9C) begin
      fails++; $display("FAIL shift_lookup: got %h want 9c", lookup_addr);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data, cursor} !== {1'b1, 7'd1, 8'h41, 7'd2}) begin
      fails++; $display("FAIL shift_write: we=%b addr=%0d data=%h cur=%0d want 1 1 41 2",
                        buf_we, buf_addr, buf_data, cursor);
    end
    @(negedge clk);
    press(8'hF0, 1); press(8'h1C, 1);
    tests++;
    if (shift_held !== 1'b1) begin fails++; $display("FAIL shift_kept: got %b want 1", shift_held); end
    press(8'hF0, 1); press(8'h12, 1);
    tests++;
    if (shift_held !== 1'b0) begin fails++; $display("FAIL shift_release: got %b want 0", shift_held); end
    tests++;
    if (we_cnt - snap !== 1) begin
      fails++; $display("FAIL shift_writes: got %0d want 1", we_cnt - snap);
    end
  endtask

  task automatic test_ignored;
    snap = we_cnt;
    press(8'hE0, 1); press(8'h1C, 1);
    press(8'hE0, 1); press(8'h12, 1);
    tests++;
    if (shift_held !== 1'b0) begin fails++; $display("FAIL ext_shift: got %b want 0", shift_held); end
    press(8'h83, 1);
    send(8'h1C, 1'b1); repeat (3) @(negedge clk);
    press(8'h76, 1);
    tests++;
    if ({we_cnt - snap, cursor} !== {32'd0, 7'd2}) begin
      fails++; $display("FAIL ignored_keys: writes=%0d cur=%0d want 0 2", we_cnt - snap, cursor);
    end
    press(8'hF0, 1);
    send(8'h1C, 1'b1); repeat (3) @(negedge clk);
    press(8'h12, 1);
    tests++;
    if (shift_held !== 1'b1) begin fails++; $display("FAIL err_clears_brk: got %b want 1", shift_held); end
    press(8'hF0, 1); press(8'h12, 1);
  endtask

  task automatic test_backspace;
    press(8'h1C, 3);
    send(8'h66, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data, cursor} !== {1'b1, 7'd4, 8'h20, 7'd4}) begin
      fails++; $display("FAIL bksp_write: we=%b addr=%0d data=%h cur=%0d want 1 4 20 4",
                        buf_we, buf_addr, buf_data, cursor);
    end
    @(negedge clk);
    press(8'h66, 4);
    snap = we_cnt;
    press(8'h66, 1);
    tests++;
    if ({we_cnt - snap, cursor} !== {32'd0, 7'd0}) begin
      fails++; $display("FAIL bksp_zero: writes=%0d cur=%0d want 0 0", we_cnt - snap, cursor);
    end
  endtask

  task automatic test_enter;
    press(8'h1C, 13);
    snap = we_cnt;
    press(8'h5A, 1);
    tests++;
    if ({we_cnt - snap, cursor} !== {32'd0, 7'd24}) begin
      fails++; $display("FAIL enter_13: writes=%0d cur=%0d want 0 24", we_cnt - snap, cursor);
    end
    press(8'h5A, 6); press(8'h1C, 4);
    tests++;
    if (cursor !== 7'd100) begin fails++; $display("FAIL enter_setup: got %0d want 100", cursor); end
    press(8'h5A, 1);
    tests++;
    if (cursor !== 7'd0) begin fails++; $display("FAIL enter_wrap: got %0d want 0", cursor); end
    press(8'h5A, 8); press(8'h1C, 11);
    send(8'h1C, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data, cursor} !== {1'b1, 7'd107, 8'h61, 7'd0}) begin
      fails++; $display("FAIL cursor_wrap: we=%b addr=%0d data=%h cur=%0d want 1 107 61 0",
                        buf_we, buf_addr, buf_data, cursor);
    end
    @(negedge clk);
  endtask

  task automatic test_overrun;
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre: got %b want 0", overrun); end
    snap = we_cnt;
    send(8'h1C, 1'b0);
    @(negedge clk);
    rx_data = 8'h15; read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
    tests++;
    if ({buf_we, buf_addr, buf_data, overrun} !== {1'b1, 7'd0, 8'h61, 1'b1}) begin
      fails++; $display("FAIL overrun_write: we=%b addr=%0d data=%h ovr=%b want 1 0 61 1",
                        buf_we, buf_addr, buf_data, overrun);
    end
    repeat (6) @(negedge clk);
    tests++;
    if ({we_cnt - snap, cursor} !== {32'd1, 7'd1}) begin
      fails++; $display("FAIL overrun_drop: writes=%0d cur=%0d want 1 1", we_cnt - snap, cursor);
    end
  endtask

  task automatic test_clear;
    int bad;
    do_reset;
    press(8'h5A, 3); press(8'h1C, 4);
    tests++;
    if (cursor !== 7'd40) begin fails++; $display("FAIL clear_setup: got %0d want 40", cursor); end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bad = 0;
    for (int i = 0; i < 108; i++) begin
      tests++;
      if ({buf_we, busy, buf_addr, buf_data} !== {1'b1, 1'b1, 7'(i), 8'h20}) begin
        fails++; bad++;
        if (bad < 4) $display("FAIL clear_cell%0d: we=%b busy=%b addr=%0d data=%h want 1 1 %0d 20",
                              i, buf_we, busy, buf_addr, buf_data, i);
      end
      @(negedge clk);
    end
    tests++;
    if ({buf_we, busy, cursor} !== {1'b0, 1'b0, 7'd0}) begin
      fails++; $display("FAIL clear_end: we=%b busy=%b cur=%0d want 0 0 0", buf_we, busy, cursor);
    end
  endtask

  task automatic test_clear_pending;
    @(negedge clk);
    rx_data = 8'h1C; read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data, cursor} !== {1'b1, 7'd0, 8'h61, 7'd1}) begin
      fails++; $display("FAIL pend_char: we=%b addr=%0d data=%h cur=%0d want 1 0 61 1",
                        buf_we, buf_addr, buf_data, cursor);
    end
    @(negedge clk);
    tests++;
    if ({buf_we, busy, buf_addr, buf_data} !== {1'b1, 1'b1, 7'd0, 8'h20}) begin
      fails++; $display("FAIL pend_clear: we=%b busy=%b addr=%0d data=%h want 1 1 0 20",
                        buf_we, busy, buf_addr, buf_data);
    end
    repeat (108) @(negedge clk);
    tests++;
    if ({buf_we, busy, cursor} !== {1'b0, 1'b0, 7'd0}) begin
      fails++; $display("FAIL pend_end: we=%b busy=%b cur=%0d want 0 0 0", buf_we, busy, cursor);
    end
  endtask

  task automatic test_clear_vs_byte;
    do_reset;
    @(negedge clk);
    clear = 1'b1; rx_data = 8'h1C; read_data = 1'b1;
    @(negedge clk);
    clear = 1'b0; read_data = 1'b0;
    snap = we_cnt;
    tests++;
    if ({overrun, buf_we, buf_addr, buf_data, lookup_addr} !== {2'b11, 7'd0, 8'h20, 8'h00}) begin
      fails++; $display("FAIL clr_vs_byte: ovr=%b we=%b addr=%0d data=%h la=%h want 1 1 0 20 00",
                        overrun, buf_we, buf_addr, buf_data, lookup_addr);
    end
    repeat (110) @(negedge clk);
    tests++;
    if (we_cnt - snap !== 108) begin
      fails++; $display("FAIL clr_vs_byte_cnt: got %0d want 108", we_cnt - snap);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({buf_we, busy, overrun, cursor, buf_addr} !== {3'b000, 7'd0, 7'd0}) begin
      fails++; $display("FAIL reset_abort: we=%b busy=%b ovr=%b cur=%0d addr=%0d want 0 0 0 0 0",
                        buf_we, busy, overrun, cursor, buf_addr);
    end
    @(negedge clk);
    snap = we_cnt;
    repeat (3) @(negedge clk);
    tests++;
    if (we_cnt - snap !== 0) begin
      fails++; $display("FAIL reset_hold_we: got %0d want 0", we_cnt - snap);
    end
  endtask

  task automatic test_first_byte;
    rst_n = 1'b1; rx_data = 8'h1C; read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
    tests++;
    if (lookup_addr !== 8'h1C) begin
      fails++; $display("FAIL first_byte_lookup: got %h want 1c", lookup_addr);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data, cursor} !== {1'b1, 7'd0, 8'h61, 7'd1}) begin
      fails++; $display("FAIL first_byte_write: we=%b addr=%0d data=%h cur=%0d want 1 0 61 1",
                        buf_we, buf_addr, buf_data, cursor);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rx_data = 8'h1C; read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data} !== {1'b1, 7'd1, 8'h61}) begin
      fails++; $display("FAIL b2b_first: we=%b addr=%0d data=%h want 1 1 61", buf_we, buf_addr, buf_data);
    end
    rx_data = 8'h15; read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
    tests++;
    if ({buf_we, overrun} !== 2'b00) begin
      fails++; $display("FAIL b2b_gap: we=%b ovr=%b want 0 0", buf_we, overrun);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({buf_we, buf_addr, buf_data, cursor} !== {1'b1, 7'd2, 8'h71, 7'd3}) begin
      fails++; $display("FAIL b2b_second: we=%b addr=%0d data=%h cur=%0d want 1 2 71 3",
                        buf_we, buf_addr, buf_data, cursor);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (burst_err !== 0) begin fails++; $display("FAIL we_burst: got %0d want 0", burst_err); end
  endtask

  initial begin
    test_reset;
    test_char;
    test_shift;
    test_ignored;
    test_backspace;
    test_enter;
    test_overrun;
    test_clear;
    test_clear_pending;
    test_clear_vs_byte;
    test_reset_abort;
    test_first_byte;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
